// File: rtl/pattern_source_32bit.sv
// pattern_source_32bit: deterministic 32-bit word stream generator with optional burst length,
// feeding the read-throughput test FIFO.
module pattern_source_32bit #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] LFSR_TAPS = 32'h80200003
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      pattern,
    input  logic [31:0]      burst_len,
    input  logic             start,
    input  logic             restart,
    input  logic             enable_gener,
    output logic [WIDTH-1:0] dataout,
    output logic             dataout_available,
    output logic             busy,
    output logic             done,
    output logic [31:0]      words_generated
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [2:0]       mode;
    logic [31:0]      len_q;
    logic [WIDTH-1:0] gen_state;
    logic [WIDTH-1:0] init_val;
    logic [WIDTH-1:0] next_val;
    logic [15:0]      seed_in;
    logic [31:0]      count_nx;
    logic             unused;

    assign unused   = ^pattern[15:3];
    assign seed_in  = pattern[31:16];
    assign count_nx = words_generated + 32'd1;
    assign busy     = state == RUN;
    assign done     = state == DONE;

    // Modes 5-7 fall through to the counter pattern in both expressions.
    always_comb begin
        init_val = pattern[2:0] == 3'd1 ? 32'h1 :
                   pattern[2:0] == 3'd2 ? (seed_in == 16'h0 ? 32'h1 : {16'h0, seed_in}) :
                   pattern[2:0] == 3'd3 ? 32'hAAAAAAAA :
                   pattern[2:0] == 3'd4 ? {seed_in, seed_in} : {16'h0, seed_in};
        next_val = mode == 3'd1 ? {gen_state[WIDTH-2:0], gen_state[WIDTH-1]} :
                   mode == 3'd2 ? (gen_state >> 1) ^ (gen_state[0] ? LFSR_TAPS : 32'h0) :
                   mode == 3'd3 ? ~gen_state :
                   mode == 3'd4 ? gen_state : gen_state + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            mode              <= 3'd0;
            len_q             <= 32'd0;
            gen_state         <= '0;
            dataout           <= '0;
            dataout_available <= 1'b0;
            words_generated   <= 32'd0;
        end else if (restart) begin
            state             <= IDLE;
            dataout_available <= 1'b0;
            words_generated   <= 32'd0;
        end else if (start) begin
            state             <= RUN;
            mode              <= pattern[2:0];
            len_q             <= burst_len;
            gen_state         <= init_val;
            dataout_available <= 1'b0;
            words_generated   <= 32'd0;
        end else if (state == RUN && enable_gener) begin
            dataout           <= gen_state;
            dataout_available <= 1'b1;
            words_generated   <= count_nx;
            gen_state         <= next_val;
            if (len_q != 32'd0 && count_nx == len_q)
                state <= DONE;
        end else begin
            dataout_available <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pattern_source_32bit.sv
// tb_pattern_source_32bit: directed scenario tasks for pattern_source_32bit with hand-computed words.
module tb_pattern_source_32bit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pattern = 32'h0;
    logic [31:0] burst_len = 32'h0;
    logic        start = 1'b0;
    logic        restart = 1'b0;
    logic        enable_gener = 1'b0;
    logic [31:0] dataout;
    logic        dataout_available;
    logic        busy;
    logic        done;
    logic [31:0] words_generated;
    int          checks = 0;
    int          errors = 0;

    pattern_source_32bit dut (
        .clk(clk), .reset_n(reset_n), .pattern(pattern), .burst_len(burst_len),
        .start(start), .restart(restart), .enable_gener(enable_gener),
        .dataout(dataout), .dataout_available(dataout_available), .busy(busy),
        .done(done), .words_generated(words_generated)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        enable_gener = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (dataout_available !== 1'b0) begin
                errors++;
                $display("FAIL reset_avail cycle %0d got %b exp 0", i, dataout_available);
            end
        end
        checks++;
        if ({dataout, busy, done, words_generated} !== 66'h0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h busy=%b done=%b cnt=%h exp all 0",
                     dataout, busy, done, words_generated);
        end
    endtask

    task automatic test_cnt_burst;
        logic [31:0] exp_w [4] = '{32'h10, 32'h11, 32'h12, 32'h13};
        pattern = 32'h0010_0000;
        burst_len = 32'd4;
        enable_gener = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || dataout_available !== 1'b0) begin
            errors++;
            $display("FAIL cnt_start got busy=%b avail=%b exp busy=1 avail=0", busy, dataout_available);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (dataout_available !== 1'b1 || dataout !== exp_w[i] || done !== (i == 3)) begin
                errors++;
                $display("FAIL cnt_word%0d got avail=%b data=%h done=%b exp avail=1 data=%h done=%b",
                         i, dataout_available, dataout, done, exp_w[i], i == 3);
            end
        end
        checks++;
        if (words_generated !== 32'd4) begin
            errors++;
            $display("FAIL cnt_count got %0d exp 4", words_generated);
        end
        tick();
        tick();
        checks++;
        if (dataout_available !== 1'b0 || done !== 1'b1 || dataout !== 32'h13 || words_generated !== 32'd4) begin
            errors++;
            $display("FAIL cnt_no_fifth got avail=%b done=%b data=%h cnt=%0d exp avail=0 done=1 data=13 cnt=4",
                     dataout_available, done, dataout, words_generated);
        end
    endtask

    task automatic test_walk_gaps;
        logic        en_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp_d  [6] = '{32'h1, 32'h1, 32'h2, 32'h4, 32'h4, 32'h8};
        pattern = 32'h0000_0001;
        burst_len = 32'd0;
        enable_gener = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            enable_gener = en_seq[i];
            tick();
            checks++;
            if (dataout_available !== en_seq[i] || dataout !== exp_d[i]) begin
                errors++;
                $display("FAIL walk_step%0d got avail=%b data=%h exp avail=%b data=%h",
                         i, dataout_available, dataout, en_seq[i], exp_d[i]);
            end
        end
        checks++;
        if (words_generated !== 32'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL walk_count got cnt=%0d busy=%b exp cnt=4 busy=1", words_generated, busy);
        end
        enable_gener = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic test_lfsr;
        logic [31:0] exp_w [3] = '{32'h00000001, 32'h80200003, 32'hC0300002};
        pattern = 32'h0000_0002;
        burst_len = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        enable_gener = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dataout_available !== 1'b1 || dataout !== exp_w[i]) begin
                errors++;
                $display("FAIL lfsr_word%0d got avail=%b data=%h exp avail=1 data=%h",
                         i, dataout_available, dataout, exp_w[i]);
            end
        end
        checks++;
        if (words_generated !== 32'd3 || done !== 1'b1) begin
            errors++;
            $display("FAIL lfsr_end got cnt=%0d done=%b exp cnt=3 done=1", words_generated, done);
        end
    endtask

    task automatic test_alt_restart;
        pattern = 32'h0000_0003;
        burst_len = 32'd0;
        enable_gener = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (dataout !== 32'h55555555 || words_generated !== 32'd2) begin
            errors++;
            $display("FAIL alt_words got data=%h cnt=%0d exp data=55555555 cnt=2", dataout, words_generated);
        end
        pattern = 32'h0000_0000;
        restart = 1'b1;
        start = 1'b1;
        tick();
        restart = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dataout_available !== 1'b0 || words_generated !== 32'd0) begin
            errors++;
            $display("FAIL alt_restart got busy=%b done=%b avail=%b cnt=%0d exp all 0",
                     busy, done, dataout_available, words_generated);
        end
        pattern = 32'h0000_0003;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (dataout_available !== 1'b1 || dataout !== 32'hAAAAAAAA || words_generated !== 32'd1) begin
            errors++;
            $display("FAIL alt_rerun got avail=%b data=%h cnt=%0d exp avail=1 data=aaaaaaaa cnt=1",
                     dataout_available, dataout, words_generated);
        end
    endtask

    task automatic test_async_reset;
        pattern = 32'h1234_0004;
        burst_len = 32'd0;
        enable_gener = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (dataout !== 32'h12341234) begin
            errors++;
            $display("FAIL const_word got %h exp 12341234", dataout);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({dataout, dataout_available, busy, done, words_generated} !== 67'h0) begin
            errors++;
            $display("FAIL async_clear got data=%h avail=%b busy=%b done=%b cnt=%h exp all 0",
                     dataout, dataout_available, busy, done, words_generated);
        end
        #8;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (dataout_available !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset%0d got avail=%b busy=%b exp 0 0", i, dataout_available, busy);
            end
        end
        pattern = 32'h00FF_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (dataout_available !== 1'b1 || dataout !== 32'h000000FF) begin
            errors++;
            $display("FAIL post_reset_start got avail=%b data=%h exp avail=1 data=000000ff",
                     dataout_available, dataout);
        end
    endtask

    initial begin
        test_reset();
        test_cnt_burst();
        test_walk_gaps();
        test_lfsr();
        test_alt_restart();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
